trap_ctl: RTL and testbench

Consumer side of the exception interface. Takes the prioritised exception request from the MEM-stage exception encoder, plus mret/sret requests, and commits the trap. Commit means: update the trap CSRs, switch privilege, assert a one-cycle `t_flush`, and present the redirect PC to fetch. Owns the M/S trap CSRs and serves them through a simple CSR read/write port.

---
 rtl/trap_ctl_pkg.sv | 41 ++++
 rtl/trap_csr.sv | 156 +++++++++++++++
 rtl/trap_ctl.sv | 156 +++++++++++++++
 tb/tb_trap_ctl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/trap_ctl_pkg.sv
// Shared constants for the trap controller: CSR map, causes,
// privilege encodings, mstatus layout and FSM state encoding.
package trap_ctl_pkg;

    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEDELEG = 12'h302;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned CAUSE_ILLEGAL = 2;
    localparam int unsigned CAUSE_BREAK   = 3;
    localparam int unsigned CAUSE_ECALL_U = 8;
    localparam int unsigned CAUSE_ECALL_S = 9;
    localparam int unsigned CAUSE_ECALL_M = 11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int MS_SIE  = 1;
    localparam int MS_MIE  = 3;
    localparam int MS_SPIE = 5;
    localparam int MS_MPIE = 7;
    localparam int MS_SPP  = 8;
    localparam int MS_MPP  = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_RET,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/trap_csr.sv
// M/S trap CSR storage: software writes, trap/return side effects
// and the combinational read mux.
module trap_csr
    import trap_ctl_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr_i,
    input  logic            csr_we_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_hit_o,
    input  logic            ev_mtrap_i,
    input  logic            ev_strap_i,
    input  logic            ev_mret_i,
    input  logic            ev_sret_i,
    input  logic [XLEN-1:0] tr_cause_i,
    input  logic [XLEN-1:0] tr_val_i,
    input  logic [XLEN-1:0] tr_pc_i,
    input  logic [1:0]      cur_priv_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] stvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] sepc_o,
    output logic [15:0]     medeleg_o,
    output logic [1:0]      mpp_o,
    output logic            spp_o
);

    logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, mtvec_q;
    logic [XLEN-1:0] sepc_q, scause_q, stval_q, stvec_q;
    logic [15:0]     medeleg_q;
    logic            mie_q, mpie_q, sie_q, spie_q, spp_q;
    logic [1:0]      mpp_q;
    logic [XLEN-1:0] epc_mask, wpc, tpc, mstatus, sstatus;

    assign epc_mask = ~XLEN'(1);
    assign wpc      = csr_wdata_i & epc_mask;
    assign tpc      = tr_pc_i & epc_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            mepc_q    <= '0;
            mcause_q  <= '0;
            mtval_q   <= '0;
            mtvec_q   <= XLEN'(MTVEC_RST);
            sepc_q    <= '0;
            scause_q  <= '0;
            stval_q   <= '0;
            stvec_q   <= '0;
            medeleg_q <= '0;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
            mpp_q     <= 2'b00;
            sie_q     <= 1'b0;
            spie_q    <= 1'b0;
            spp_q     <= 1'b0;
        end else begin
            if (csr_we_i) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        mie_q  <= csr_wdata_i[MS_MIE];
                        mpie_q <= csr_wdata_i[MS_MPIE];
                        mpp_q  <= csr_wdata_i[MS_MPP+1:MS_MPP];
                        sie_q  <= csr_wdata_i[MS_SIE];
                        spie_q <= csr_wdata_i[MS_SPIE];
                        spp_q  <= csr_wdata_i[MS_SPP];
                    end
                    CSR_SSTATUS: begin
                        sie_q  <= csr_wdata_i[MS_SIE];
                        spie_q <= csr_wdata_i[MS_SPIE];
                        spp_q  <= csr_wdata_i[MS_SPP];
                    end
                    CSR_MEDELEG: medeleg_q <= csr_wdata_i[15:0] & 16'hF7FF;
                    CSR_MTVEC:   mtvec_q   <= csr_wdata_i;
                    CSR_MEPC:    mepc_q    <= wpc;
                    CSR_MCAUSE:  mcause_q  <= csr_wdata_i;
                    CSR_MTVAL:   mtval_q   <= csr_wdata_i;
                    CSR_STVEC:   stvec_q   <= csr_wdata_i;
                    CSR_SEPC:    sepc_q    <= wpc;
                    CSR_SCAUSE:  scause_q  <= csr_wdata_i;
                    CSR_STVAL:   stval_q   <= csr_wdata_i;
                    default: ;
                endcase
            end
            if (ev_mtrap_i) begin
                mepc_q   <= tpc;
                mcause_q <= tr_cause_i;
                mtval_q  <= tr_val_i;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
                mpp_q    <= cur_priv_i;
            end
            if (ev_strap_i) begin
                sepc_q   <= tpc;
                scause_q <= tr_cause_i;
                stval_q  <= tr_val_i;
                spie_q   <= sie_q;
                sie_q    <= 1'b0;
                spp_q    <= cur_priv_i[0];
            end
            if (ev_mret_i) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
                mpp_q  <= PRIV_U;
            end
            if (ev_sret_i) begin
                sie_q  <= spie_q;
                spie_q <= 1'b1;
                spp_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        sstatus          = '0;
        sstatus[MS_SIE]  = sie_q;
        sstatus[MS_SPIE] = spie_q;
        sstatus[MS_SPP]  = spp_q;
        mstatus          = sstatus;
        mstatus[MS_MIE]  = mie_q;
        mstatus[MS_MPIE] = mpie_q;
        mstatus[MS_MPP+1:MS_MPP] = mpp_q;
    end

    always_comb begin
        csr_rdata_o = '0;
        csr_hit_o   = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS: csr_rdata_o = mstatus;
            CSR_MEDELEG: csr_rdata_o = XLEN'(medeleg_q);
            CSR_MTVEC:   csr_rdata_o = mtvec_q;
            CSR_MEPC:    csr_rdata_o = mepc_q;
            CSR_MCAUSE:  csr_rdata_o = mcause_q;
            CSR_MTVAL:   csr_rdata_o = mtval_q;
            CSR_SSTATUS: csr_rdata_o = sstatus;
            CSR_STVEC:   csr_rdata_o = stvec_q;
            CSR_SEPC:    csr_rdata_o = sepc_q;
            CSR_SCAUSE:  csr_rdata_o = scause_q;
            CSR_STVAL:   csr_rdata_o = stval_q;
            default:     csr_hit_o   = 1'b0;
        endcase
    end

    assign mtvec_o   = mtvec_q;
    assign stvec_o   = stvec_q;
    assign mepc_o    = mepc_q;
    assign sepc_o    = sepc_q;
    assign medeleg_o = medeleg_q;
    assign mpp_o     = mpp_q;
    assign spp_o     = spp_q;

endmodule

// File: rtl/trap_ctl.sv
// Trap commit controller: accepts exception/xRET requests from MEM,
// switches privilege, and issues a flush plus redirect PC.
module trap_ctl
    import trap_ctl_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_val,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            mret,
    input  logic            sret,
    input  logic            stall_mem,
    input  logic [11:0]     csr_addr,
    input  logic            csr_we,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_hit,
    output logic [1:0]      priv,
    output logic            t_busy,
    output logic            t_flush,
    output logic [XLEN-1:0] t_pc
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d, val_q, val_d, pc_q, pc_d;
    logic [XLEN-1:0] tpc_q, tpc_d;
    logic [1:0]      priv_q, priv_d;
    logic            retm_q, retm_d;
    logic            accept, del;
    logic            ev_mtrap, ev_strap, ev_mret, ev_sret;
    logic [XLEN-1:0] mtvec, stvec, mepc, sepc, vmask;
    logic [15:0]     medeleg;
    logic [1:0]      mpp;
    logic            spp;

    assign vmask = ~XLEN'(3);

    // Only standard synchronous causes below 16 can be delegated.
    assign del = (priv_q != PRIV_M) && (cause_q[XLEN-1:4] == '0)
               && medeleg[cause_q[3:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
            val_q   <= '0;
            pc_q    <= '0;
            tpc_q   <= '0;
            priv_q  <= PRIV_M;
            retm_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            val_q   <= val_d;
            pc_q    <= pc_d;
            tpc_q   <= tpc_d;
            priv_q  <= priv_d;
            retm_q  <= retm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        val_d    = val_q;
        pc_d     = pc_q;
        tpc_d    = tpc_q;
        priv_d   = priv_q;
        retm_d   = retm_q;
        accept   = 1'b0;
        ev_mtrap = 1'b0;
        ev_strap = 1'b0;
        ev_mret  = 1'b0;
        ev_sret  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!stall_mem && (exc || mret || sret)) begin
                    accept  = 1'b1;
                    pc_d    = exc_pc;
                    state_d = ST_TRAP;
                    if (exc) begin
                        cause_d = exc_cause;
                        val_d   = exc_val;
                    end else if ((mret && priv_q != PRIV_M)
                              || (!mret && priv_q == PRIV_U)) begin
                        cause_d = XLEN'(CAUSE_ILLEGAL);
                        val_d   = '0;
                    end else begin
                        retm_d  = mret;
                        state_d = ST_RET;
                    end
                end
            end
            ST_TRAP: begin
                ev_strap = del;
                ev_mtrap = !del;
                priv_d   = del ? PRIV_S : PRIV_M;
                tpc_d    = (del ? stvec : mtvec) & vmask;
                state_d  = ST_FLUSH;
            end
            ST_RET: begin
                ev_mret = retm_q;
                ev_sret = !retm_q;
                if (retm_q) begin
                    priv_d = (mpp == 2'b10) ? PRIV_U : mpp;
                    tpc_d  = mepc;
                end else begin
                    priv_d = {1'b0, spp};
                    tpc_d  = sepc;
                end
                state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    trap_csr #(
        .XLEN      (XLEN),
        .MTVEC_RST (MTVEC_RST)
    ) u_csr (
        .clk         (clk),
        .rst         (rst),
        .csr_addr_i  (csr_addr),
        .csr_we_i    (csr_we && state_q == ST_IDLE && !accept),
        .csr_wdata_i (csr_wdata),
        .csr_rdata_o (csr_rdata),
        .csr_hit_o   (csr_hit),
        .ev_mtrap_i  (ev_mtrap),
        .ev_strap_i  (ev_strap),
        .ev_mret_i   (ev_mret),
        .ev_sret_i   (ev_sret),
        .tr_cause_i  (cause_q),
        .tr_val_i    (val_q),
        .tr_pc_i     (pc_q),
        .cur_priv_i  (priv_q),
        .mtvec_o     (mtvec),
        .stvec_o     (stvec),
        .mepc_o      (mepc),
        .sepc_o      (sepc),
        .medeleg_o   (medeleg),
        .mpp_o       (mpp),
        .spp_o       (spp)
    );

    assign priv    = priv_q;
    assign t_busy  = (state_q != ST_IDLE);
    assign t_flush = (state_q == ST_FLUSH);
    assign t_pc    = tpc_q;

endmodule

// File: tb/tb_trap_ctl.sv
// Scoreboard bench for trap_ctl: expected redirects queued at request
// time, matched against each t_flush pulse.
module tb_trap_ctl;
    import trap_ctl_pkg::*;

    typedef struct {
        logic [63:0] tpc;
        logic [1:0]  prv;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc = 1'b0, mret = 1'b0, sret = 1'b0, stall_mem = 1'b0;
    logic [63:0] exc_cause = '0, exc_val = '0, exc_pc = '0;
    logic [11:0] csr_addr = '0;
    logic        csr_we = 1'b0;
    logic [63:0] csr_wdata = '0;
    logic [63:0] csr_rdata, t_pc;
    logic        csr_hit, t_busy, t_flush;
    logic [1:0]  priv;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0, n_flush = 0, cyc = 0;

    trap_ctl dut (
        .clk(clk), .rst(rst), .exc(exc), .exc_cause(exc_cause),
        .exc_val(exc_val), .exc_pc(exc_pc), .mret(mret), .sret(sret),
        .stall_mem(stall_mem), .csr_addr(csr_addr), .csr_we(csr_we),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
        .priv(priv), .t_busy(t_busy), .t_flush(t_flush), .t_pc(t_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (t_flush) begin
            exp_t e;
            n_flush++;
            if (sb.size() == 0) begin
                chk("unexp_flush", 64'(n_flush), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("t_pc", t_pc, e.tpc);
                chk("priv", 64'(priv), 64'(e.prv));
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
        tick();
        csr_addr = a; csr_we = 1'b1; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [11:0] a,
                           input logic [63:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic do_req(input logic e, input logic m, input logic s,
                          input logic [63:0] cause, input logic [63:0] val,
                          input logic [63:0] pc, input logic [63:0] etpc,
                          input logic [1:0] eprv, input int nstall);
        exp_t x;
        int   f0;
        f0 = n_flush;
        tick();
        exc = e; mret = m; sret = s;
        exc_cause = cause; exc_val = val; exc_pc = pc;
        stall_mem = (nstall > 0);
        x.tpc = etpc; x.prv = eprv; x.cyc = cyc + nstall + 2;
        sb.push_back(x);
        for (int i = 0; i < nstall; i++) begin
            tick();
            chk("stall_busy", 64'(t_busy), 64'(0));
        end
        stall_mem = 1'b0;
        tick();
        exc = 1'b0; mret = 1'b0; sret = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("sb_drain", 64'(sb.size()), 64'(0));
        repeat (3) tick();
        chk("one_flush", 64'(n_flush - f0), 64'(1));
    endtask

    initial begin
        int f0;
        repeat (2) tick();
        chk("rst_priv", 64'(priv), 64'(3));
        chk("rst_flush", 64'(t_flush), 64'(0));
        chk("rst_busy", 64'(t_busy), 64'(0));
        chk("rst_tpc", t_pc, 64'h0);
        csr_chk("rst_mtvec", CSR_MTVEC, 64'h8000_0000);
        csr_chk("rst_mstatus", CSR_MSTATUS, 64'h0);
        rst = 1'b0;
        csr_addr = 12'h7C0;
        #1;
        chk("unmap_hit", 64'(csr_hit), 64'(0));
        chk("unmap_data", csr_rdata, 64'h0);

        do_req(1, 0, 0, 64'd11, 64'h0, 64'h8000_0100,
               64'h8000_0000, PRIV_M, 0);
        csr_chk("t1_mepc", CSR_MEPC, 64'h8000_0100);
        csr_chk("t1_mcause", CSR_MCAUSE, 64'd11);
        csr_chk("t1_mstatus", CSR_MSTATUS, 64'h1800);

        csr_wr(CSR_MSTATUS, 64'h8);
        do_req(1, 0, 0, 64'd3, 64'h0, 64'h100,
               64'h8000_0000, PRIV_M, 0);
        csr_chk("t2_mstatus", CSR_MSTATUS, 64'h1880);
        do_req(0, 1, 0, 64'h0, 64'h0, 64'h104, 64'h100, PRIV_M, 0);
        csr_chk("t2_ret_mstatus", CSR_MSTATUS, 64'h88);

        csr_wr(CSR_MEDELEG, 64'h10900);
        csr_chk("medeleg_mask", CSR_MEDELEG, 64'h100);
        csr_wr(CSR_STVEC, 64'h4001);
        csr_chk("stvec_rd", CSR_STVEC, 64'h4001);
        csr_wr(CSR_MEPC, 64'h3001);
        csr_chk("mepc_bit0", CSR_MEPC, 64'h3000);
        csr_wr(CSR_SSTATUS, 64'h2);
        do_req(0, 1, 0, 64'h0, 64'h0, 64'h104, 64'h3000, PRIV_U, 0);
        do_req(1, 0, 0, 64'd8, 64'h0, 64'h2000, 64'h4000, PRIV_S, 0);
        csr_chk("t3_sepc", CSR_SEPC, 64'h2000);
        csr_chk("t3_scause", CSR_SCAUSE, 64'd8);
        csr_chk("t3_sstatus", CSR_SSTATUS, 64'h20);
        csr_chk("t3_mcause", CSR_MCAUSE, 64'd3);

        do_req(0, 1, 0, 64'h0, 64'h0, 64'h2100,
               64'h8000_0000, PRIV_M, 0);
        csr_chk("t4_mcause", CSR_MCAUSE, 64'd2);
        csr_chk("t4_mepc", CSR_MEPC, 64'h2100);
        csr_chk("t4_mtval", CSR_MTVAL, 64'h0);
        csr_chk("t4_mstatus", CSR_MSTATUS, 64'h8A0);

        csr_wr(CSR_MTVEC, 64'h5003);
        do_req(1, 0, 0, 64'd11, 64'h55, 64'h400, 64'h5000, PRIV_M, 3);
        csr_chk("t5_mtval", CSR_MTVAL, 64'h55);
        csr_chk("t5_mepc", CSR_MEPC, 64'h400);

        f0 = n_flush;
        tick();
        exc = 1'b1; exc_cause = 64'd11; exc_pc = 64'h600;
        csr_addr = CSR_MTVEC; csr_we = 1'b1; csr_wdata = 64'h9000;
        tick();
        exc = 1'b0; csr_we = 1'b0; rst = 1'b1;
        chk("t6_busy", 64'(t_busy), 64'(1));
        csr_chk("t6_wr_drop", CSR_MTVEC, 64'h5003);
        tick();
        chk("t6_flush", 64'(t_flush), 64'(0));
        chk("t6_busy_rst", 64'(t_busy), 64'(0));
        chk("t6_priv", 64'(priv), 64'(3));
        csr_chk("t6_mtvec", CSR_MTVEC, 64'h8000_0000);
        rst = 1'b0;
        repeat (4) tick();
        chk("t6_no_flush", 64'(n_flush - f0), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
